// File: rtl/uart_pkg.sv
// Shared UART constants: byte width and receive FIFO defaults.
package uart_pkg;
  localparam int UART_DATA_W       = 8;
  localparam int RX_FIFO_DEPTH     = 16;
  localparam int RX_FIFO_AF_MARGIN = 2;
endpackage

// File: rtl/rx_fifo_mem.sv
// DEPTH x UART_DATA_W storage: synchronous write, asynchronous read, array not reset.
module rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// Receive byte FIFO behind the UART receiver: one push per rx_done rise, FWFT valid/ready output.
// Optional drop counter output when RX_FIFO_DROP_CNT_EN is defined.
module rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = RX_FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - RX_FIFO_AF_MARGIN
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_W-1:0]    rx_data,
  input  logic                      rx_done,
  output logic                      rx_en,
  output logic [UART_DATA_W-1:0]    m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      overflow,
  input  logic                      ovf_clr
`ifdef RX_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]                drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);

  logic          done_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] level_nxt;
  logic          push, pop, wr_en, drop, empty;

  assign push  = rx_done & ~done_q;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign m_valid = ~empty;
  assign pop     = m_valid & m_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en   = push & (~full | pop);
  assign drop    = push & full & ~pop;

  assign level_nxt = level + PW'(wr_en) - PW'(pop);

  rx_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (m_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rx_en    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done_q <= rx_done;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      level <= level_nxt;
      rx_en <= (level_nxt < AF_L);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

`ifdef RX_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Scoreboard bench for rx_fifo: queue-based reference model plus a negedge monitor.
module tb_rx_fifo;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;

  logic       clk = 1'b0;
  logic       rst, rx_done, m_ready, ovf_clr;
  logic [7:0] rx_data;
  logic       rx_en, m_valid, full, overflow;
  logic [7:0] m_data;
  logic [4:0] level;
`ifdef RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_en    (rx_en),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .level    (level),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
`ifdef RX_FIFO_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus occupancy count, updated on each rising clock.
  byte unsigned exp_q[$];
  int  m_level = 0;
  bit  m_prev  = 1'b1;
  bit  m_ovf   = 1'b0;
  bit  m_rxen  = 1'b0;
  int  m_drops = 0;
  bit  started = 1'b0;
  bit  mp_push, mp_pop, mp_drop;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_level = 0; m_prev = 1'b1; m_ovf = 1'b0; m_rxen = 1'b0; m_drops = 0;
      started = 1'b1;
    end else if (started) begin
      mp_push = rx_done && !m_prev;
      mp_pop  = (m_level > 0) && m_ready;
      mp_drop = 1'b0;
      if (mp_pop) m_level--;
      if (mp_push) begin
        if (m_level < DEPTH) begin
          exp_q.push_back(rx_data);
          m_level++;
        end else begin
          mp_drop = 1'b1;
        end
      end
      if (mp_drop)      m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      if (mp_drop)      m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
      else if (ovf_clr) m_drops = 0;
      m_rxen = (m_level < AF);
      m_prev = rx_done;
    end
  end

  bit         hold_chk  = 1'b0;
  logic [7:0] hold_dat;
  int         last_pop  = -1;

  always @(negedge clk) begin
    if (started) begin
      chk("m_valid", int'(m_valid), int'(m_level > 0));
      chk("level", int'(level), m_level);
      chk("full", int'(full), int'(m_level == DEPTH));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("rx_en", int'(rx_en), int'(m_rxen));
`ifdef RX_FIFO_DROP_CNT_EN
      chk("drop_cnt", int'(drop_cnt), m_drops);
`endif
      if (hold_chk && m_valid) chk("m_data_hold", int'(m_data), int'(hold_dat));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_unexpected", 1, 0);
        end else begin
          last_pop = int'(exp_q.pop_front());
          chk("m_data", int'(m_data), last_pop);
        end
      end
      hold_chk = m_valid && !m_ready && !rst;
      hold_dat = m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int hold, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) tick();
    rx_done = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  int cnt;
  int rdy_pct;

  initial begin
    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00; m_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rx_en_after_reset", int'(rx_en), 1);

    // Long rx_done level yields exactly one byte.
    send(8'h55, 2000, 2);
    chk("long_done_level", int'(level), 1);
    chk("long_done_data", int'(m_data), 8'h55);

    // Fill to full, then overflow and clear.
    do_reset();
    tick();
    for (int i = 1; i <= DEPTH; i++) send(8'(i), 3, 2);
    chk("fill_full", int'(full), 1);
    chk("fill_rx_en", int'(rx_en), 0);
    send(8'hAA, 3, 2);
    chk("drop_overflow", int'(overflow), 1);
    chk("drop_level", int'(level), DEPTH);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();
    chk("ovf_clr", int'(overflow), 0);

    // Push into full FIFO with a same-cycle pop.
    rx_data = 8'hBB; rx_done = 1'b1; m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    repeat (2) tick();
    rx_done = 1'b0;
    tick();
    chk("full_pushpop_level", int'(level), DEPTH);
    chk("full_pushpop_ovf", int'(overflow), 0);
    m_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    chk("drain_level", int'(level), 0);
    chk("drain_last", last_pop, 8'hBB);

    // Reset mid-operation with rx_done high.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h40 + 8'(i), 2, 2);
    chk("pre_reset_level", int'(level), 5);
    rx_data = 8'h77; rx_done = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("reset_level", int'(level), 0);
    chk("reset_valid", int'(m_valid), 0);
    rx_done = 1'b0; tick();
    send(8'h33, 2, 2);
    chk("post_reset_push", int'(level), 1);
    chk("post_reset_data", int'(m_data), 8'h33);

    // Randomised traffic with varying consumer readiness.
    cnt = 0;
    for (int c = 0; c < 6000; c++) begin
      if (c % 1000 == 0) rdy_pct = (c % 2000 == 0) ? 15 : 80;
      if (cnt == 0) begin
        if (!rx_done) rx_data = 8'($urandom);
        rx_done = ~rx_done;
        cnt = $urandom_range(1, 4);
      end
      cnt--;
      m_ready = ($urandom_range(0, 99) < rdy_pct);
      ovf_clr = ($urandom_range(0, 31) == 0);
      rst     = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst = 1'b0; ovf_clr = 1'b0; rx_done = 1'b0; m_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    chk("random_drain", int'(level), 0);

`ifdef RX_FIFO_DROP_CNT_EN
    // Saturating drop counter.
    do_reset();
    m_ready = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1, 1);
    for (int i = 0; i < 300; i++) send(8'hE0, 1, 1);
    chk("drop_cnt_sat", int'(drop_cnt), 255);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; tick();
    chk("drop_cnt_clr", int'(drop_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
